// File: rtl/axi_resp_router_if.sv
// Handshake and response-path bundle between the AXI return router and its
// surroundings; the router takes the slave modport.
interface axi_resp_router_if #(
    parameter int DATA_W = 32
);
    logic              m_arvalid;
    logic              m_arready;
    logic              rd_slave2_sel;
    logic              m_awvalid;
    logic              m_awready;
    logic              wr_slave2_sel;

    logic [DATA_W-1:0] s1_rdata;
    logic [DATA_W-1:0] s2_rdata;
    logic [1:0]        s1_rresp;
    logic [1:0]        s2_rresp;
    logic              s1_rlast;
    logic              s2_rlast;
    logic              s1_rvalid;
    logic              s2_rvalid;
    logic              s1_rready;
    logic              s2_rready;

    logic [DATA_W-1:0] m_rdata;
    logic [1:0]        m_rresp;
    logic              m_rlast;
    logic              m_rvalid;
    logic              m_rready;

    logic [1:0]        s1_bresp;
    logic [1:0]        s2_bresp;
    logic              s1_bvalid;
    logic              s2_bvalid;
    logic              s1_bready;
    logic              s2_bready;

    logic [1:0]        m_bresp;
    logic              m_bvalid;
    logic              m_bready;

    logic              rd_full;
    logic              wr_full;
    logic              rd_ovf;
    logic              wr_ovf;

    modport slave (
        input  m_arvalid, m_arready, rd_slave2_sel,
        input  m_awvalid, m_awready, wr_slave2_sel,
        input  s1_rdata, s2_rdata, s1_rresp, s2_rresp,
        input  s1_rlast, s2_rlast, s1_rvalid, s2_rvalid,
        output s1_rready, s2_rready,
        output m_rdata, m_rresp, m_rlast, m_rvalid,
        input  m_rready,
        input  s1_bresp, s2_bresp, s1_bvalid, s2_bvalid,
        output s1_bready, s2_bready,
        output m_bresp, m_bvalid,
        input  m_bready,
        output rd_full, wr_full, rd_ovf, wr_ovf
    );

    modport master (
        output m_arvalid, m_arready, rd_slave2_sel,
        output m_awvalid, m_awready, wr_slave2_sel,
        output s1_rdata, s2_rdata, s1_rresp, s2_rresp,
        output s1_rlast, s2_rlast, s1_rvalid, s2_rvalid,
        input  s1_rready, s2_rready,
        input  m_rdata, m_rresp, m_rlast, m_rvalid,
        output m_rready,
        output s1_bresp, s2_bresp, s1_bvalid, s2_bvalid,
        input  s1_bready, s2_bready,
        input  m_bresp, m_bvalid,
        output m_bready,
        input  rd_full, wr_full, rd_ovf, wr_ovf
    );
endinterface

// File: rtl/axi_resp_router.sv
// Return-path router: per-channel order FIFOs steer R and B from the owning
// slave back to the master strictly in AR/AW issue order.
module axi_resp_router #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2
) (
    input  logic             clk,
    input  logic             rst,
    axi_resp_router_if.slave bus
);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [DEPTH-1:0]  r_rd_mem;
    logic [PTR_W-1:0]  r_rd_wptr;
    logic [PTR_W-1:0]  r_rd_rptr;
    logic [PTR_W:0]    r_rd_cnt;
    logic              r_rd_ovf;

    logic [DEPTH-1:0]  r_wr_mem;
    logic [PTR_W-1:0]  r_wr_wptr;
    logic [PTR_W-1:0]  r_wr_rptr;
    logic [PTR_W:0]    r_wr_cnt;
    logic              r_wr_ovf;

    logic              w_rd_full;
    logic              w_rd_hv;
    logic              w_rd_sel;
    logic              w_rd_push;
    logic              w_rd_push_ok;
    logic              w_rd_pop;

    logic              w_wr_full;
    logic              w_wr_hv;
    logic              w_wr_sel;
    logic              w_wr_push;
    logic              w_wr_push_ok;
    logic              w_wr_pop;

    logic [DATA_W-1:0] w_rdata;
    logic [1:0]        w_rresp;
    logic              w_rlast;
    logic              w_rvalid;
    logic              w_s1_rready;
    logic              w_s2_rready;

    logic [1:0]        w_bresp;
    logic              w_bvalid;
    logic              w_s1_bready;
    logic              w_s2_bready;

    assign w_rd_full    = (r_rd_cnt == FULL_CNT);
    assign w_rd_hv      = (r_rd_cnt != '0);
    assign w_rd_sel     = r_rd_mem[r_rd_rptr];
    assign w_rd_push    = bus.m_arvalid & bus.m_arready;
    assign w_rd_push_ok = w_rd_push & ~w_rd_full;
    assign w_rd_pop     = w_rvalid & bus.m_rready & w_rlast;

    assign w_wr_full    = (r_wr_cnt == FULL_CNT);
    assign w_wr_hv      = (r_wr_cnt != '0);
    assign w_wr_sel     = r_wr_mem[r_wr_rptr];
    assign w_wr_push    = bus.m_awvalid & bus.m_awready;
    assign w_wr_push_ok = w_wr_push & ~w_wr_full;
    assign w_wr_pop     = w_bvalid & bus.m_bready;

    // Non-owning slave always sees ready low, so out-of-turn data is held.
    always_comb begin
        w_rdata     = '0;
        w_rresp     = '0;
        w_rlast     = 1'b0;
        w_rvalid    = 1'b0;
        w_s1_rready = 1'b0;
        w_s2_rready = 1'b0;
        if (w_rd_hv) begin
            if (w_rd_sel) begin
                w_rdata     = bus.s2_rdata;
                w_rresp     = bus.s2_rresp;
                w_rlast     = bus.s2_rlast;
                w_rvalid    = bus.s2_rvalid;
                w_s2_rready = bus.m_rready;
            end else begin
                w_rdata     = bus.s1_rdata;
                w_rresp     = bus.s1_rresp;
                w_rlast     = bus.s1_rlast;
                w_rvalid    = bus.s1_rvalid;
                w_s1_rready = bus.m_rready;
            end
        end
    end

    always_comb begin
        w_bresp     = '0;
        w_bvalid    = 1'b0;
        w_s1_bready = 1'b0;
        w_s2_bready = 1'b0;
        if (w_wr_hv) begin
            if (w_wr_sel) begin
                w_bresp     = bus.s2_bresp;
                w_bvalid    = bus.s2_bvalid;
                w_s2_bready = bus.m_bready;
            end else begin
                w_bresp     = bus.s1_bresp;
                w_bvalid    = bus.s1_bvalid;
                w_s1_bready = bus.m_bready;
            end
        end
    end

    // A push while full is dropped even if a pop frees a slot this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_mem  <= '0;
            r_rd_wptr <= '0;
            r_rd_rptr <= '0;
            r_rd_cnt  <= '0;
            r_rd_ovf  <= 1'b0;
        end else begin
            if (w_rd_push && w_rd_full)
                r_rd_ovf <= 1'b1;
            if (w_rd_push_ok) begin
                r_rd_mem[r_rd_wptr] <= bus.rd_slave2_sel;
                r_rd_wptr           <= r_rd_wptr + PTR_ONE;
            end
            if (w_rd_pop)
                r_rd_rptr <= r_rd_rptr + PTR_ONE;
            case ({w_rd_push_ok, w_rd_pop})
                2'b10:   r_rd_cnt <= r_rd_cnt + CNT_ONE;
                2'b01:   r_rd_cnt <= r_rd_cnt - CNT_ONE;
                default: r_rd_cnt <= r_rd_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_mem  <= '0;
            r_wr_wptr <= '0;
            r_wr_rptr <= '0;
            r_wr_cnt  <= '0;
            r_wr_ovf  <= 1'b0;
        end else begin
            if (w_wr_push && w_wr_full)
                r_wr_ovf <= 1'b1;
            if (w_wr_push_ok) begin
                r_wr_mem[r_wr_wptr] <= bus.wr_slave2_sel;
                r_wr_wptr           <= r_wr_wptr + PTR_ONE;
            end
            if (w_wr_pop)
                r_wr_rptr <= r_wr_rptr + PTR_ONE;
            case ({w_wr_push_ok, w_wr_pop})
                2'b10:   r_wr_cnt <= r_wr_cnt + CNT_ONE;
                2'b01:   r_wr_cnt <= r_wr_cnt - CNT_ONE;
                default: r_wr_cnt <= r_wr_cnt;
            endcase
        end
    end

    assign bus.m_rdata   = w_rdata;
    assign bus.m_rresp   = w_rresp;
    assign bus.m_rlast   = w_rlast;
    assign bus.m_rvalid  = w_rvalid;
    assign bus.s1_rready = w_s1_rready;
    assign bus.s2_rready = w_s2_rready;

    assign bus.m_bresp   = w_bresp;
    assign bus.m_bvalid  = w_bvalid;
    assign bus.s1_bready = w_s1_bready;
    assign bus.s2_bready = w_s2_bready;

    assign bus.rd_full   = w_rd_full;
    assign bus.wr_full   = w_wr_full;
    assign bus.rd_ovf    = r_rd_ovf;
    assign bus.wr_ovf    = r_wr_ovf;
endmodule

// File: tb/tb_axi_resp_router.sv
// Bench for axi_resp_router: read-path vector table, write full/overflow and
// reset sequences, then random traffic against a queue-based order model.
`timescale 1ns/1ps
module tb_axi_resp_router;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int NRAND  = 400;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_resp_router_if #(.DATA_W(DATA_W)) bus();

    axi_resp_router #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .PTR_W (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        ar;
        logic        sel;
        logic        s1v;
        logic [31:0] s1d;
        logic        s1l;
        logic        s2v;
        logic [31:0] s2d;
        logic        s2l;
        logic        mrr;
        logic        ev;
        logic [31:0] ed;
        logic        el;
        logic        er1;
        logic        er2;
        logic        efull;
        logic        eovf;
    } rvec_t;

    rvec_t tbl[$];

    logic rq[$];
    logic wq[$];
    logic m_rovf;
    logic m_wovf;
    logic hv;
    logic hs;
    logic full;
    logic [DATA_W+3:0] exp_r;
    logic [2:0]        exp_b;
    logic [1:0]        exp_rr;
    logic [1:0]        exp_br;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.m_arvalid     = 1'b0;
        bus.m_arready     = 1'b0;
        bus.rd_slave2_sel = 1'b0;
        bus.m_awvalid     = 1'b0;
        bus.m_awready     = 1'b0;
        bus.wr_slave2_sel = 1'b0;
        bus.s1_rdata      = '0;
        bus.s2_rdata      = '0;
        bus.s1_rresp      = '0;
        bus.s2_rresp      = '0;
        bus.s1_rlast      = 1'b0;
        bus.s2_rlast      = 1'b0;
        bus.s1_rvalid     = 1'b0;
        bus.s2_rvalid     = 1'b0;
        bus.m_rready      = 1'b0;
        bus.s1_bresp      = '0;
        bus.s2_bresp      = '0;
        bus.s1_bvalid     = 1'b0;
        bus.s2_bvalid     = 1'b0;
        bus.m_bready      = 1'b0;
    endtask

    function automatic rvec_t mk(int ar, int sel, int s1v, int s1d, int s1l,
                                 int s2v, int s2d, int s2l, int mrr,
                                 int ev, int ed, int el, int er1, int er2,
                                 int ef, int eo);
        rvec_t v;
        v.ar    = (ar != 0);
        v.sel   = (sel != 0);
        v.s1v   = (s1v != 0);
        v.s1d   = s1d;
        v.s1l   = (s1l != 0);
        v.s2v   = (s2v != 0);
        v.s2d   = s2d;
        v.s2l   = (s2l != 0);
        v.mrr   = (mrr != 0);
        v.ev    = (ev != 0);
        v.ed    = ed;
        v.el    = (el != 0);
        v.er1   = (er1 != 0);
        v.er2   = (er2 != 0);
        v.efull = (ef != 0);
        v.eovf  = (eo != 0);
        return v;
    endfunction

    initial begin
        // ar sel s1v s1d s1l s2v s2d s2l mrr | v d l r1 r2 full ovf
        tbl.push_back(mk(0,0, 0,'h00,0, 0,'h00,0, 0,  0,'h00,0, 0,0, 0,0));
        tbl.push_back(mk(1,0, 1,'hA0,0, 0,'h00,0, 1,  0,'h00,0, 0,0, 0,0));
        tbl.push_back(mk(0,0, 1,'hA0,0, 0,'h00,0, 1,  1,'hA0,0, 1,0, 0,0));
        tbl.push_back(mk(0,0, 1,'hA1,0, 0,'h00,0, 1,  1,'hA1,0, 1,0, 0,0));
        tbl.push_back(mk(0,0, 1,'hA2,0, 0,'h00,0, 1,  1,'hA2,0, 1,0, 0,0));
        tbl.push_back(mk(0,0, 1,'hA3,1, 0,'h00,0, 1,  1,'hA3,1, 1,0, 0,0));
        tbl.push_back(mk(0,0, 1,'hA4,0, 0,'h00,0, 1,  0,'h00,0, 0,0, 0,0));
        tbl.push_back(mk(1,1, 0,'h00,0, 0,'h00,0, 0,  0,'h00,0, 0,0, 0,0));
        tbl.push_back(mk(1,0, 1,'h11,1, 0,'h22,0, 1,  0,'h22,0, 0,1, 0,0));
        tbl.push_back(mk(0,0, 1,'h11,1, 1,'h20,0, 1,  1,'h20,0, 0,1, 0,0));
        tbl.push_back(mk(0,0, 1,'h11,1, 1,'h21,1, 1,  1,'h21,1, 0,1, 0,0));
        tbl.push_back(mk(0,0, 1,'h11,1, 0,'h00,0, 1,  1,'h11,1, 1,0, 0,0));
        tbl.push_back(mk(1,1, 0,'h00,0, 0,'h00,0, 0,  0,'h00,0, 0,0, 0,0));
        tbl.push_back(mk(1,0, 0,'h00,0, 1,'h30,1, 1,  1,'h30,1, 0,1, 0,0));
        tbl.push_back(mk(0,0, 1,'h31,0, 1,'h99,1, 1,  1,'h31,0, 1,0, 0,0));
        tbl.push_back(mk(0,0, 1,'h32,1, 0,'h00,0, 1,  1,'h32,1, 1,0, 0,0));
        tbl.push_back(mk(1,1, 0,'h00,0, 0,'h00,0, 0,  0,'h00,0, 0,0, 0,0));
        tbl.push_back(mk(0,0, 0,'h00,0, 1,'h40,1, 0,  1,'h40,1, 0,0, 0,0));
        tbl.push_back(mk(0,0, 0,'h00,0, 1,'h40,1, 0,  1,'h40,1, 0,0, 0,0));
        tbl.push_back(mk(0,0, 0,'h00,0, 1,'h40,1, 0,  1,'h40,1, 0,0, 0,0));
        tbl.push_back(mk(0,0, 0,'h00,0, 1,'h40,1, 1,  1,'h40,1, 0,1, 0,0));
        tbl.push_back(mk(0,0, 0,'h00,0, 1,'h41,1, 1,  0,'h00,0, 0,0, 0,0));
        tbl.push_back(mk(1,0, 0,'h00,0, 0,'h00,0, 0,  0,'h00,0, 0,0, 0,0));
        tbl.push_back(mk(1,1, 0,'h00,0, 0,'h00,0, 0,  0,'h00,0, 0,0, 0,0));
        tbl.push_back(mk(1,0, 0,'h00,0, 0,'h00,0, 0,  0,'h00,0, 0,0, 0,0));
        tbl.push_back(mk(1,1, 0,'h00,0, 0,'h00,0, 0,  0,'h00,0, 0,0, 0,0));
        tbl.push_back(mk(1,0, 0,'h00,0, 0,'h00,0, 0,  0,'h00,0, 0,0, 1,0));
        tbl.push_back(mk(0,0, 1,'h50,1, 0,'h00,0, 1,  1,'h50,1, 1,0, 1,1));
        tbl.push_back(mk(0,0, 0,'h00,0, 1,'h51,1, 1,  1,'h51,1, 0,1, 0,1));
        tbl.push_back(mk(0,0, 1,'h52,1, 0,'h00,0, 1,  1,'h52,1, 1,0, 0,1));
        tbl.push_back(mk(0,0, 0,'h00,0, 1,'h53,1, 1,  1,'h53,1, 0,1, 0,1));
        tbl.push_back(mk(0,0, 1,'h54,1, 0,'h00,0, 1,  0,'h00,0, 0,0, 0,1));

        idle();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_rvalid", bus.m_rvalid, 0);
        chk("rst_bvalid", bus.m_bvalid, 0);
        chk("rst_flags",
            {bus.rd_full, bus.wr_full, bus.rd_ovf, bus.wr_ovf}, 0);
        chk("rst_readies",
            {bus.s1_rready, bus.s2_rready, bus.s1_bready, bus.s2_bready}, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < tbl.size(); i++) begin
            bus.m_arvalid     = tbl[i].ar;
            bus.m_arready     = tbl[i].ar;
            bus.rd_slave2_sel = tbl[i].sel;
            bus.s1_rvalid     = tbl[i].s1v;
            bus.s1_rdata      = tbl[i].s1d;
            bus.s1_rlast      = tbl[i].s1l;
            bus.s2_rvalid     = tbl[i].s2v;
            bus.s2_rdata      = tbl[i].s2d;
            bus.s2_rlast      = tbl[i].s2l;
            bus.m_rready      = tbl[i].mrr;
            #1;
            chk($sformatf("row%0d_rvalid", i), bus.m_rvalid, tbl[i].ev);
            chk($sformatf("row%0d_rdata", i), bus.m_rdata, tbl[i].ed);
            chk($sformatf("row%0d_rlast", i), bus.m_rlast, tbl[i].el);
            chk($sformatf("row%0d_rready", i),
                {bus.s1_rready, bus.s2_rready}, {tbl[i].er1, tbl[i].er2});
            chk($sformatf("row%0d_rd_full", i), bus.rd_full, tbl[i].efull);
            chk($sformatf("row%0d_rd_ovf", i), bus.rd_ovf, tbl[i].eovf);
            tick();
        end

        // Write channel: fill, overflow, then drain in issue order.
        idle();
        for (int i = 0; i < 4; i++) begin
            bus.m_awvalid     = 1'b1;
            bus.m_awready     = 1'b1;
            bus.wr_slave2_sel = i[0];
            #1;
            chk("wr_full_filling", bus.wr_full, 0);
            tick();
        end
        bus.m_awvalid = 1'b0;
        bus.m_awready = 1'b0;
        bus.s1_bvalid = 1'b1;
        bus.s1_bresp  = 2'd2;
        #1;
        chk("wr_full_after4", bus.wr_full, 1);
        chk("wr_head_s1", {bus.m_bvalid, bus.m_bresp}, 3'b110);
        chk("wr_hold_ready", {bus.s1_bready, bus.s2_bready}, 0);
        bus.m_awvalid     = 1'b1;
        bus.m_awready     = 1'b1;
        bus.wr_slave2_sel = 1'b1;
        tick();
        bus.m_awvalid = 1'b0;
        bus.m_awready = 1'b0;
        #1;
        chk("wr_ovf_set", bus.wr_ovf, 1);
        chk("wr_full_held", bus.wr_full, 1);
        bus.m_bready  = 1'b1;
        bus.s1_bresp  = 2'd1;
        bus.s2_bvalid = 1'b1;
        bus.s2_bresp  = 2'd3;
        #1;
        chk("wr_pop1_b", {bus.m_bvalid, bus.m_bresp}, 3'b101);
        chk("wr_pop1_rdy", {bus.s1_bready, bus.s2_bready}, 2'b10);
        tick();
        chk("wr_full_clear", bus.wr_full, 0);
        chk("wr_pop2_b", {bus.m_bvalid, bus.m_bresp}, 3'b111);
        chk("wr_pop2_rdy", {bus.s1_bready, bus.s2_bready}, 2'b01);
        tick();
        chk("wr_pop3_b", {bus.m_bvalid, bus.m_bresp}, 3'b101);
        chk("wr_pop3_rdy", {bus.s1_bready, bus.s2_bready}, 2'b10);
        tick();
        chk("wr_pop4_b", {bus.m_bvalid, bus.m_bresp}, 3'b111);
        chk("wr_pop4_rdy", {bus.s1_bready, bus.s2_bready}, 2'b01);
        tick();
        chk("wr_empty_b", bus.m_bvalid, 0);
        chk("wr_empty_rdy", {bus.s1_bready, bus.s2_bready}, 0);
        chk("wr_ovf_sticky", bus.wr_ovf, 1);

        // Reset in the middle of a four-beat s1 burst.
        idle();
        bus.m_arvalid = 1'b1;
        bus.m_arready = 1'b1;
        tick();
        bus.m_arvalid = 1'b0;
        bus.m_arready = 1'b0;
        bus.s1_rvalid = 1'b1;
        bus.m_rready  = 1'b1;
        bus.s1_rdata  = 32'h60;
        tick();
        bus.s1_rdata  = 32'h61;
        #1;
        chk("mid_beat2", {bus.m_rvalid, bus.m_rdata}, {1'b1, 32'h61});
        tick();
        bus.s1_rdata = 32'h62;
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_rvalid", bus.m_rvalid, 0);
        chk("rst_mid_flags",
            {bus.rd_full, bus.rd_ovf, bus.wr_ovf}, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_empty", {bus.m_rvalid, bus.s1_rready}, 0);
        tick();
        chk("post_rst_empty2", {bus.m_rvalid, bus.s1_rready}, 0);

        // Random traffic against an issue-order queue model.
        idle();
        m_rovf = 1'b0;
        m_wovf = 1'b0;
        for (int n = 0; n < NRAND; n++) begin
            bus.m_arvalid     = ($urandom_range(0, 2) == 0);
            bus.m_arready     = $urandom_range(0, 1);
            bus.rd_slave2_sel = $urandom_range(0, 1);
            bus.m_awvalid     = ($urandom_range(0, 2) == 0);
            bus.m_awready     = $urandom_range(0, 1);
            bus.wr_slave2_sel = $urandom_range(0, 1);
            bus.s1_rdata      = $urandom;
            bus.s2_rdata      = $urandom;
            bus.s1_rresp      = 2'($urandom_range(0, 3));
            bus.s2_rresp      = 2'($urandom_range(0, 3));
            bus.s1_rlast      = ($urandom_range(0, 4) < 2);
            bus.s2_rlast      = ($urandom_range(0, 4) < 2);
            bus.s1_rvalid     = ($urandom_range(0, 4) < 3);
            bus.s2_rvalid     = ($urandom_range(0, 4) < 3);
            bus.m_rready      = ($urandom_range(0, 3) != 0);
            bus.s1_bresp      = 2'($urandom_range(0, 3));
            bus.s2_bresp      = 2'($urandom_range(0, 3));
            bus.s1_bvalid     = ($urandom_range(0, 2) == 0);
            bus.s2_bvalid     = ($urandom_range(0, 2) == 0);
            bus.m_bready      = ($urandom_range(0, 3) != 0);
            #1;

            hv = (rq.size() != 0);
            hs = hv ? rq[0] : 1'b0;
            exp_r  = '0;
            exp_rr = '0;
            if (hv && hs) begin
                exp_r  = {bus.s2_rvalid, bus.s2_rlast, bus.s2_rresp, bus.s2_rdata};
                exp_rr = {1'b0, bus.m_rready};
            end else if (hv) begin
                exp_r  = {bus.s1_rvalid, bus.s1_rlast, bus.s1_rresp, bus.s1_rdata};
                exp_rr = {bus.m_rready, 1'b0};
            end
            chk($sformatf("rand%0d_r", n),
                {bus.m_rvalid, bus.m_rlast, bus.m_rresp, bus.m_rdata}, exp_r);
            chk($sformatf("rand%0d_rready", n),
                {bus.s1_rready, bus.s2_rready}, exp_rr);
            chk($sformatf("rand%0d_rflags", n), {bus.rd_full, bus.rd_ovf},
                {rq.size() == DEPTH, m_rovf});
            full = (rq.size() == DEPTH);
            if (exp_r[DATA_W+3] && exp_r[DATA_W+2] && bus.m_rready)
                void'(rq.pop_front());
            if (bus.m_arvalid && bus.m_arready) begin
                if (full) m_rovf = 1'b1;
                else      rq.push_back(bus.rd_slave2_sel);
            end

            hv = (wq.size() != 0);
            hs = hv ? wq[0] : 1'b0;
            exp_b  = '0;
            exp_br = '0;
            if (hv && hs) begin
                exp_b  = {bus.s2_bvalid, bus.s2_bresp};
                exp_br = {1'b0, bus.m_bready};
            end else if (hv) begin
                exp_b  = {bus.s1_bvalid, bus.s1_bresp};
                exp_br = {bus.m_bready, 1'b0};
            end
            chk($sformatf("rand%0d_b", n), {bus.m_bvalid, bus.m_bresp}, exp_b);
            chk($sformatf("rand%0d_bready", n),
                {bus.s1_bready, bus.s2_bready}, exp_br);
            chk($sformatf("rand%0d_wflags", n), {bus.wr_full, bus.wr_ovf},
                {wq.size() == DEPTH, m_wovf});
            full = (wq.size() == DEPTH);
            if (exp_b[2] && bus.m_bready)
                void'(wq.pop_front());
            if (bus.m_awvalid && bus.m_awready) begin
                if (full) m_wovf = 1'b1;
                else      wq.push_back(bus.wr_slave2_sel);
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
